// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache-line burst adaptor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } line_adaptor_state_t;

    // Byte address of beat k of a line starting at base. Callers truncate to
    // their own address width, which gives modulo-2^ADDR_W arithmetic.
    function automatic logic [63:0] beat_addr(input logic [63:0] base,
                                              input int unsigned k,
                                              input int unsigned word_w);
        return base + 64'(k) * 64'(word_w / 8);
    endfunction

endpackage

// File: rtl/cacheline_burst_adaptor_if.sv
// Bundles the cache-side line port and the memory-side word port.
// Latency: n/a (wiring only).
// Backpressure: line_req valid/ready toward the cache, mem valid/ready toward memory.
interface cacheline_burst_adaptor_if #(
    parameter int LINE_W = 256,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
);
    // Cache side
    logic              line_req_valid;
    logic              line_req_ready;
    logic              line_req_we;
    logic [ADDR_W-1:0] line_req_addr;
    logic [LINE_W-1:0] line_wdata;
    logic              line_resp_valid;
    logic [LINE_W-1:0] line_rdata;
    // Memory side
    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [WORD_W-1:0] mem_rdata;

    // The adaptor's own view.
    modport slave (
        input  line_req_valid, line_req_we, line_req_addr, line_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output line_req_ready, line_resp_valid, line_rdata,
        output mem_valid, mem_we, mem_addr, mem_wdata
    );

    // The surrounding cache controller and memory.
    modport master (
        output line_req_valid, line_req_we, line_req_addr, line_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  line_req_ready, line_resp_valid, line_rdata,
        input  mem_valid, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/burst_ctr.sv
// Beat counter for one burst direction (issue or return), 0..BEATS.
// Latency: count visible the cycle after inc.
// Backpressure: none; caller qualifies inc with its own handshake.
module burst_ctr #(
    parameter int BEATS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [$clog2(BEATS):0] cnt,
    output logic                  last
);
    localparam int CW = $clog2(BEATS) + 1;

    // Count handshaked beats; clear takes priority so a new burst starts at 0.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign last = (cnt == CW'(BEATS - 1));

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Splits a cache-line write into WORD_W memory beats and gathers a read burst into one line.
// Latency: accept to line_resp_valid >= BEATS+1 cycles (plus read latency and mem stalls).
// Backpressure: one request in flight; line_req_ready only in IDLE, beats held until mem_ready.
module cacheline_burst_adaptor
    import cache_pkg::*;
#(
    parameter int LINE_W = 256,   // integer multiple of WORD_W
    parameter int WORD_W = 32,    // multiple of 8
    parameter int ADDR_W = 32     // at most 64
) (
    input  logic                       clk,
    input  logic                       rst,
    cacheline_burst_adaptor_if.slave   bus
);
    localparam int BEATS = LINE_W / WORD_W;      // power of 2, >= 2
    localparam int IDX_W = $clog2(BEATS);
    localparam int CW    = IDX_W + 1;
    localparam int OFS_W = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((64'd1 << OFS_W) - 64'd1);

    line_adaptor_state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q;
    logic [LINE_W-1:0] line_buf;

    logic [CW-1:0]     issue_cnt, ret_cnt;
    logic              issue_last, ret_last;
    logic [IDX_W-1:0]  issue_idx, ret_idx;

    logic              req_ready, accept, beat_acc, ret_ok, issue_pending;
    logic              resp_valid;
    logic              mem_valid_o, mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o, cur_addr;
    logic [WORD_W-1:0] mem_wdata_o, cur_wdata;
    logic [LINE_W-1:0] rdata_o;

    assign issue_idx = issue_cnt[IDX_W-1:0];
    assign ret_idx   = ret_cnt[IDX_W-1:0];

    // Beat address and data are decoded purely from registered state, so they
    // stay put for as long as the memory withholds mem_ready.
    assign cur_addr  = ADDR_W'(beat_addr(64'(base_q), 32'(issue_idx), 32'(WORD_W)));
    assign cur_wdata = line_buf[int'(issue_idx)*WORD_W +: WORD_W];

    assign issue_pending = (state_q == READ) && (issue_cnt < CW'(BEATS));
    assign accept        = bus.line_req_valid && req_ready;
    assign beat_acc      = mem_valid_o && bus.mem_ready;

    // A return is legal only for a beat already issued, counting one being
    // accepted this very cycle so zero-latency memories are supported.
    assign ret_ok = (state_q == READ) && bus.mem_rvalid &&
                    (ret_cnt < (issue_cnt + CW'(beat_acc)));

    burst_ctr #(.BEATS(BEATS)) u_issue_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == IDLE),
        .inc  (beat_acc),
        .cnt  (issue_cnt),
        .last (issue_last)
    );

    burst_ctr #(.BEATS(BEATS)) u_ret_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == IDLE),
        .inc  (ret_ok),
        .cnt  (ret_cnt),
        .last (ret_last)
    );

    // State register; reset aborts any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: writes finish on the last beat accepted, reads on the last beat returned.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = bus.line_req_we ? WRITE : READ;
            WRITE:   if (beat_acc && issue_last) state_d = RESP;
            READ:    if (ret_ok && ret_last) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: all forced low while rst is high, otherwise decoded from state.
    always_comb begin
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_valid_o = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        rdata_o     = '0;
        if (!rst) begin
            rdata_o = line_buf;
            case (state_q)
                IDLE:  req_ready = 1'b1;
                WRITE: begin
                    mem_valid_o = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = cur_addr;
                    mem_wdata_o = cur_wdata;
                end
                READ: begin
                    if (issue_pending) begin
                        mem_valid_o = 1'b1;
                        mem_addr_o  = cur_addr;
                    end
                end
                RESP:    resp_valid = 1'b1;
                default: ;
            endcase
        end
    end

    // Line buffer: loaded on accept, patched one word per legal read return.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= '0;
            line_buf <= '0;
        end else if (accept) begin
            base_q   <= bus.line_req_addr & ~OFS_MASK;
            line_buf <= bus.line_wdata;
        end else if (ret_ok) begin
            line_buf[int'(ret_idx)*WORD_W +: WORD_W] <= bus.mem_rdata;
        end
    end

    assign bus.line_req_ready  = req_ready;
    assign bus.line_resp_valid = resp_valid;
    assign bus.line_rdata      = rdata_o;
    assign bus.mem_valid       = mem_valid_o;
    assign bus.mem_we          = mem_we_o;
    assign bus.mem_addr        = mem_addr_o;
    assign bus.mem_wdata       = mem_wdata_o;

endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
Parametrised, handshaked replacement for the fixed 256-to-32-bit cache line serializer/deserializer. It sits between the cache controller (one full line per request) and the word-wide main-memory port. It converts a line write into a burst of WORD_W beats, and gathers a read burst back into one line. It adds valid/ready flow control, address generation, and tolerance of variable read latency.

Parameters:
LINE_W, 256, cache line width in bits; must be an integer multiple of WORD_W.
WORD_W, 32, memory bus width in bits; must be a multiple of 8.
ADDR_W, 32, byte address width.
BEATS (localparam), LINE_W/WORD_W, beats per line; must be a power of 2 and at least 2.
OFS_W (localparam), $clog2(LINE_W/8), byte-offset bits of a line.

Ports:
clk  in  1  system clock, all logic on the rising edge
rst  in  1  synchronous, active-high reset
line_req_valid  in  1  cache presents a line request
line_req_ready  out  1  adaptor accepts a request
line_req_we  in  1  1 = write line to memory, 0 = read line
line_req_addr  in  ADDR_W  byte address; low OFS_W bits are ignored
line_wdata  in  LINE_W  line to write, sampled on accept
line_resp_valid  out  1  one-cycle completion pulse
line_rdata  out  LINE_W  assembled read line
mem_valid  out  1  beat request valid
mem_we  out  1  beat is a write
mem_addr  out  ADDR_W  beat byte address
mem_wdata  out  WORD_W  write beat data
mem_ready  in  1  memory accepts the current beat request
mem_rvalid  in  1  read data beat returned
mem_rdata  in  WORD_W  read data beat

Behaviour:
- Interface: one clock domain, clk. Reset rst is synchronous and active-high.
- Reset: state IDLE, all counters 0, line buffer 0.
- Output values during reset: line_req_ready=0 while rst is high, then 1 in IDLE. line_resp_valid=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, line_rdata=0.
- Accept: a request is accepted when line_req_valid && line_req_ready, which is only possible in IDLE.
  - On accept, register base = line_req_addr with the low OFS_W bits cleared.
  - Also register line_wdata into the line buffer, and register line_req_we.
- Beat mapping: beat k uses line bits [k*WORD_W +: WORD_W] at address base + k*(WORD_W/8). Beat 0 is the lowest address (little-endian).
- States: IDLE, WRITE, READ, RESP.
- IDLE -> WRITE or READ in the cycle after accept. No memory activity occurs in the accept cycle.
- WRITE:
  - Drive mem_valid=1, mem_we=1, mem_addr and mem_wdata for beat issue_cnt.
  - Outputs are registered and hold stable until mem_ready is seen.
  - Each cycle with mem_valid && mem_ready increments issue_cnt.
  - Acceptance of beat BEATS-1 moves to RESP.
  - Minimum time from accept to line_resp_valid is BEATS+1 cycles.
- READ:
  - mem_valid=1 and mem_we=0 while issue_cnt < BEATS. Requests advance on mem_ready as in WRITE.
  - Each mem_rvalid writes mem_rdata into beat ret_cnt of the buffer and increments ret_cnt. Data returns in order with arbitrary latency, including 0 (same cycle as the request acceptance).
  - An issue and a return in the same cycle are both processed.
  - The return of beat BEATS-1 moves to RESP.
- RESP:
  - line_resp_valid=1 for exactly one cycle, with line_rdata = the buffer.
  - After a write, line_rdata shows the written line.
  - Next state is IDLE. line_req_ready=0 in RESP, so back-to-back requests have a 1-cycle bubble.
- mem_rvalid is ignored outside READ, and also when ret_cnt == issue_cnt (a protocol violation; no buffer write occurs).
- line_rdata changes only on accept and on read returns.
- Reset mid-burst aborts immediately: state goes to IDLE and mem_valid drops in the next cycle. Late read returns after reset are ignored.
- Counters are $clog2(BEATS)+1 bits wide. Address arithmetic is modulo 2^ADDR_W; a line never crosses a line boundary.

Decomposition:
- Package cache_pkg: enum line_adaptor_state_t {IDLE, WRITE, READ, RESP}, and a helper function beat_addr(base, k, WORD_W).
- Sub-module burst_ctr(clk, rst, clr, inc, cnt, last):
  - Parametrised by BEATS.
  - Instantiated twice, as the issue counter and the return counter.

Test Plan:
- Write, addr 0x0000_1234, line = {8{words 0x1111_1111*k}}, mem_ready always 1 -> beats at 0x1220..0x123C with data 0x0 through 0x7777_7777; line_resp_valid in cycle 9 after accept.
- Read at 0x4000, mem_ready=1, rvalid 3 cycles after each request, beat data 0xA0+k -> line_rdata word k = 0xA0+k; exactly one resp pulse.
- Write with mem_ready low for 2 cycles on beat 3 -> mem_addr and mem_wdata held stable; no beat skipped or duplicated.
- Read with rvalid in the same cycle as request acceptance (zero latency) -> resp 1 cycle after the last return; correct line assembled.
- rst asserted mid-read after 4 beats -> next cycle mem_valid=0, state IDLE, line_req_ready=1; a stray rvalid after that is ignored, and a new read completes correctly.
- line_req_valid held high through RESP -> second request accepted only in IDLE; spurious mem_rvalid in IDLE leaves line_rdata unchanged.
